// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Sits between the EX/M and M/W pipeline
//   registers. It issues one aligned byte, half or word access on a
//   split-handshake data bus (address phase, then data phase) and stalls M
//   until the data returns. It also produces the aligned, extended load value
//   and the writeback result.
//
// Handshake: data_req is a registered request. Once raised, it stays high with
//   data_wr/size/addr/wstrb/wdata frozen until the bus answers data_addr_ok.
//   It drops on the clock edge that samples data_addr_ok. The request is never
//   withdrawn. data_data_ok completes the access: read data is valid, or the
//   write is done. It may arrive in the same cycle as data_addr_ok.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   validM..writedataM  instruction fields presented by the EX/M register
//   flush_exceptionM    exception flush of the instruction in M
//   stallW              M/W register is holding
//   data_*              data-bus master side
//   mem_rdataM          aligned, sign/zero-extended load data (0 for stores)
//   resultM             writeback value: load data or ALU result
//   mem_stallM          hold F..M while the access is outstanding
//   adelM / adesM       misaligned load / store address error
//   badvaddrM           faulting address
//   dbg_state_o         current FSM state (0 idle, 1 req, 2 wait, 3 done)
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validM,
   input  logic              memreadM,
   input  logic              memwriteM,
   input  logic [1:0]        mem_sizeM,
   input  logic              mem_signM,
   input  logic [31:0]       aluoutM,
   input  logic [31:0]       writedataM,
   input  logic              flush_exceptionM,
   input  logic              stallW,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic [31:0]       mem_rdataM,
   output logic [31:0]       resultM,
   output logic              mem_stallM,
   output logic              adelM,
   output logic              adesM,
   output logic [31:0]       badvaddrM,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q;
   logic              discard_q;
   logic [31:0]       rdata_q;
   logic              data_req_q;
   logic              data_wr_q;
   logic [1:0]        data_size_q;
   logic [ADDR_W-1:0] data_addr_q;
   logic [3:0]        data_wstrb_q;
   logic [31:0]       data_wdata_q;

   logic              access;
   logic              misalign;
   logic              go;
   logic              disc;
   logic [3:0]        wstrb_d;
   logic [31:0]       wdata_d;
   logic [31:0]       shifted;
   logic [31:0]       load_val;

   always_comb begin
      access = validM & (memreadM | memwriteM);
      case (mem_sizeM)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = aluoutM[0];
         default: misalign = |aluoutM[1:0];   // 11 behaves as word
      endcase
      go   = access & ~misalign & ~flush_exceptionM;
      // A flush arriving this cycle counts as a discard at once, so a
      // data_ok that coincides with the flush is dropped as well.
      disc = discard_q | flush_exceptionM;

      case (mem_sizeM)
         2'b00:   wstrb_d = 4'b0001 << aluoutM[1:0];
         2'b01:   wstrb_d = 4'b0011 << aluoutM[1:0];
         default: wstrb_d = 4'b1111;
      endcase
      case (mem_sizeM)
         2'b00:   wdata_d = {4{writedataM[7:0]}};
         2'b01:   wdata_d = {2{writedataM[15:0]}};
         default: wdata_d = writedataM;
      endcase

      shifted = rdata_q >> {aluoutM[1:0], 3'b000};
      case (mem_sizeM)
         2'b00:   load_val = mem_signM ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'd0, shifted[7:0]};
         2'b01:   load_val = mem_signM ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'd0, shifted[15:0]};
         default: load_val = shifted;
      endcase
      mem_rdataM = memreadM ? load_val : 32'd0;
      resultM    = memreadM ? mem_rdataM : aluoutM;

      adelM     = access & memreadM & misalign;
      adesM     = access & memwriteM & misalign;
      badvaddrM = aluoutM;

      // While draining a discarded access, M is held only when a new
      // access is waiting. That access is issued once the FSM is back in IDLE.
      case (state_q)
         S_IDLE:         mem_stallM = go;
         S_REQ, S_WAIT:  mem_stallM = disc ? go : 1'b1;
         default:        mem_stallM = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         discard_q    <= 1'b0;
         rdata_q      <= 32'd0;
         data_req_q   <= 1'b0;
         data_wr_q    <= 1'b0;
         data_size_q  <= 2'd0;
         data_addr_q  <= '0;
         data_wstrb_q <= 4'd0;
         data_wdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q      <= S_REQ;
                  data_req_q   <= 1'b1;
                  data_wr_q    <= memwriteM;
                  data_size_q  <= mem_sizeM;
                  data_addr_q  <= ADDR_W'(aluoutM);
                  data_wstrb_q <= wstrb_d;
                  data_wdata_q <= wdata_d;
               end
            end
            S_REQ: begin
               if (flush_exceptionM) discard_q <= 1'b1;
               if (data_addr_ok) begin
                  data_req_q <= 1'b0;
                  if (data_data_ok) begin
                     if (disc) begin
                        state_q   <= S_IDLE;
                        discard_q <= 1'b0;
                     end else begin
                        state_q <= S_DONE;
                        rdata_q <= data_rdata;
                     end
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (flush_exceptionM) discard_q <= 1'b1;
               if (data_data_ok) begin
                  if (disc) begin
                     state_q   <= S_IDLE;
                     discard_q <= 1'b0;
                  end else begin
                     state_q <= S_DONE;
                     rdata_q <= data_rdata;
                  end
               end
            end
            S_DONE: begin
               if (~stallW | flush_exceptionM) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data_req    = data_req_q;
   assign data_wr     = data_wr_q;
   assign data_size   = data_size_q;
   assign data_addr   = data_addr_q;
   assign data_wstrb  = data_wstrb_q;
   assign data_wdata  = data_wdata_q;
   assign dbg_state_o = state_q;

endmodule
